soc_tracker: RTL

Coulomb-counting state-of-charge tracker for the four-cell pack. It sits directly downstream of the current-split stage and consumes that stage's per-cell IEEE-754 currents `i1`..`i4`. It integrates each current into a per-cell fixed-point SOC and re-publishes SOC as IEEE-754 singles `soc1`..`soc4`, which are the values the current-split stage consumes on its next evaluation. One shared float-to-fixed converter is time-multiplexed across the four channels by a small FSM.

---
 rtl/soc_tracker.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/soc_tracker.sv
// soc_tracker: Coulomb-counting state-of-charge tracker for a four-cell pack.
// Integrates per-cell IEEE-754 currents into Q1.23 SOC registers and publishes
// SOC back as IEEE-754 singles. One float-to-fixed converter is shared across
// the four channels, sequenced by an IDLE/UPD/PACK FSM.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_ready  sample handshake for i1..i4 (IEEE-754, + = discharge)
//   ld_valid, ld_sel,   direct SOC load (Q1.23, clamped to 1.0), priority
//   ld_soc              over samples
//   soc1..soc4          registered IEEE-754 SOC
//   out_valid           one-cycle pulse when soc1..soc4 refresh
//   low_alarm[3:0]      per-cell SOC < LOW_THRESH, only when
//                       SOC_TRACKER_LOW_ALARM_EN is defined
module soc_tracker #(
  parameter int unsigned GAIN_SHIFT = 8,
  parameter logic [23:0] INIT_SOC   = 24'h800000
`ifdef SOC_TRACKER_LOW_ALARM_EN
  ,
  parameter logic [23:0] LOW_THRESH = 24'h0CCCCD
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  input  logic [31:0] i3,
  input  logic [31:0] i4,
  input  logic        ld_valid,
  input  logic [1:0]  ld_sel,
  input  logic [23:0] ld_soc,
  output logic [31:0] soc1,
  output logic [31:0] soc2,
  output logic [31:0] soc3,
  output logic [31:0] soc4,
  output logic        out_valid
`ifdef SOC_TRACKER_LOW_ALARM_EN
  ,
  output logic [3:0]  low_alarm
`endif
);

  localparam logic [23:0] SOC_FULL = 24'h800000;

  typedef enum logic [1:0] {IDLE, UPD, PACK} state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] cur_q [4];
  logic [31:0] cur_d [4];
  logic [23:0] soc_q [4];
  logic [23:0] soc_d [4];
  logic [31:0] pub_q [4];
  logic [31:0] pub_d [4];
  logic        out_valid_q, out_valid_d;
`ifdef SOC_TRACKER_LOW_ALARM_EN
  logic [3:0]  alarm_q, alarm_d;
`endif

  // IEEE-754 single to signed Q15.16, truncating toward zero.
  function automatic logic signed [31:0] f2fix(input logic [31:0] f);
    logic [7:0]  e;
    logic [23:0] man;
    logic [31:0] mag;
    e   = f[30:23];
    man = {1'b1, f[22:0]};
    if (e == 8'd0)
      mag = '0;
    else if (e == 8'd255)
      mag = (f[22:0] != '0) ? '0 : 32'h7FFF_FFFF;
    else if (e >= 8'd142)
      mag = 32'h7FFF_FFFF;
    else if (e >= 8'd134)
      mag = {8'd0, man} << (e - 8'd134);
    else if (e > 8'd110)
      mag = {8'd0, man} >> (8'd134 - e);
    else
      mag = '0;
    return f[31] ? $signed(-mag) : $signed(mag);
  endfunction

  // Discharge-positive integration step, clamped to [0, 1.0].
  function automatic logic [23:0] soc_step(input logic [23:0] soc,
                                           input logic signed [31:0] fix);
    logic signed [32:0] delta;
    logic signed [33:0] nxt;
    delta = $signed({fix[31], fix}) >>> GAIN_SHIFT;
    nxt   = $signed({10'd0, soc}) - $signed({delta[32], delta});
    if (nxt < 34'sd0)
      return '0;
    else if (nxt > $signed({10'd0, SOC_FULL}))
      return SOC_FULL;
    else
      return nxt[23:0];
  endfunction

  // Q1.23 to IEEE-754 single; exact since the value has at most 24 significant bits.
  function automatic logic [31:0] fix2f(input logic [23:0] s);
    logic [4:0]  p;
    logic [23:0] al;
    logic [7:0]  ex;
    p = '0;
    for (int unsigned i = 0; i < 24; i++)
      if (s[i]) p = i[4:0];
    al = s << (5'd23 - p);
    ex = 8'd104 + {3'd0, p};
    if (s == '0)
      return '0;
    return {1'b0, ex, al[22:0]};
  endfunction

  assign in_ready  = (state_q == IDLE) && !ld_valid;
  assign soc1      = pub_q[0];
  assign soc2      = pub_q[1];
  assign soc3      = pub_q[2];
  assign soc4      = pub_q[3];
  assign out_valid = out_valid_q;
`ifdef SOC_TRACKER_LOW_ALARM_EN
  assign low_alarm = alarm_q;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cur_d       = cur_q;
    soc_d       = soc_q;
    pub_d       = pub_q;
    out_valid_d = 1'b0;
`ifdef SOC_TRACKER_LOW_ALARM_EN
    alarm_d     = alarm_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ld_valid) begin
          soc_d[ld_sel] = (ld_soc > SOC_FULL) ? SOC_FULL : ld_soc;
          state_d       = PACK;
        end else if (in_valid) begin
          cur_d[0] = i1;
          cur_d[1] = i2;
          cur_d[2] = i3;
          cur_d[3] = i4;
          k_d      = '0;
          state_d  = UPD;
        end
      end
      UPD: begin
        soc_d[k_q] = soc_step(soc_q[k_q], f2fix(cur_q[k_q]));
        k_d        = k_q + 2'd1;
        if (k_q == 2'd3)
          state_d = PACK;
      end
      PACK: begin
        for (int unsigned n = 0; n < 4; n++) begin
          pub_d[n] = fix2f(soc_q[n]);
`ifdef SOC_TRACKER_LOW_ALARM_EN
          alarm_d[n] = (soc_q[n] < LOW_THRESH);
`endif
        end
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned n = 0; n < 4; n++) begin
        cur_q[n] <= '0;
        soc_q[n] <= INIT_SOC;
        pub_q[n] <= fix2f(INIT_SOC);
      end
`ifdef SOC_TRACKER_LOW_ALARM_EN
      alarm_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      cur_q       <= cur_d;
      soc_q       <= soc_d;
      pub_q       <= pub_d;
`ifdef SOC_TRACKER_LOW_ALARM_EN
      alarm_q     <= alarm_d;
`endif
    end
  end

endmodule
